// File: rtl/timer_pkg.sv
// Shared command codes and state encoding for the interval timer and the
// pedestrian button FSM that drives it.
package timer_pkg;

    localparam logic [3:0] SEL_NULL = 4'b0000;
    localparam logic [3:0] SEL_T1   = 4'b0001;
    localparam logic [3:0] SEL_T2   = 4'b0010;
    localparam logic [3:0] SEL_T3   = 4'b0100;
    localparam logic [3:0] SEL_T4   = 4'b1000;
    localparam logic [3:0] SEL_STOP = 4'b1111;

    localparam int NUM_TIMERS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;

    // Maps a one-hot select code to its interval index; valid is low for
    // anything that is not one of the four interval selects.
    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } sel_decode_t;

    function automatic sel_decode_t decode_sel(input logic [3:0] sel);
        sel_decode_t d;
        d.valid = 1'b0;
        d.idx   = 2'd0;
        case (sel)
            SEL_T1: begin d.valid = 1'b1; d.idx = 2'd0; end
            SEL_T2: begin d.valid = 1'b1; d.idx = 2'd1; end
            SEL_T3: begin d.valid = 1'b1; d.idx = 2'd2; end
            SEL_T4: begin d.valid = 1'b1; d.idx = 2'd3; end
            default: begin d.valid = 1'b0; d.idx = 2'd0; end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a single-cycle tick every TICK_DIV enabled clocks.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt_reg <= '0;
        end else if (en) begin
            if (cnt_reg == LAST) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + PW'(1);
            end
        end
    end

    // The wrap cycle itself is the tick, so the first tick lands TICK_DIV
    // cycles after a clear.
    assign tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/interval_timer.sv
// Four-interval down-counter timer: loads on a one-hot select strobe, aborts
// on STOP, and pulses the matching T bit for one cycle on expiry.
module interval_timer
    import timer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int DUR1     = 5,
    parameter int DUR2     = 10,
    parameter int DUR3     = 3,
    parameter int DUR4     = 15,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       sel,
    input  logic             ld,
    output logic [3:0]       T,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
);

    localparam int DURS [NUM_TIMERS] = '{DUR1, DUR2, DUR3, DUR4};

    logic [CNT_W-1:0] dur_tbl [NUM_TIMERS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TIMERS; gi++) begin : g_dur
            assign dur_tbl[gi] = CNT_W'(DURS[gi]);
        end
    endgenerate

    timer_state_t     state_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic [1:0]       idx_reg;
    logic [3:0]       t_reg;
    logic             busy_reg;

    sel_decode_t      dec;
    logic             stop_cmd;
    logic             load_cmd;
    logic             tick;

    always_comb begin
        dec      = decode_sel(sel);
        stop_cmd = (sel == SEL_STOP);
        load_cmd = ld && dec.valid;
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (stop_cmd || load_cmd),
        .en    (state_reg == RUN),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            idx_reg       <= 2'd0;
            t_reg         <= 4'b0000;
            busy_reg      <= 1'b0;
        end else begin
            t_reg <= 4'b0000;
            if (stop_cmd) begin
                // STOP wins even over an expiry landing on this very edge.
                state_reg     <= IDLE;
                remaining_reg <= '0;
                busy_reg      <= 1'b0;
            end else if (load_cmd) begin
                state_reg     <= RUN;
                remaining_reg <= dur_tbl[dec.idx];
                idx_reg       <= dec.idx;
                busy_reg      <= 1'b1;
            end else begin
                case (state_reg)
                    RUN: begin
                        if (remaining_reg == '0) begin
                            // Zero-length interval expires on the next edge.
                            state_reg <= DONE;
                            t_reg     <= 4'b0001 << idx_reg;
                            busy_reg  <= 1'b0;
                        end else if (tick) begin
                            remaining_reg <= remaining_reg - CNT_W'(1);
                            if (remaining_reg == CNT_W'(1)) begin
                                state_reg <= DONE;
                                t_reg     <= 4'b0001 << idx_reg;
                                busy_reg  <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign T         = t_reg;
    assign busy      = busy_reg;
    assign remaining = remaining_reg;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with a queue-based scoreboard on T pulses.
module tb_interval_timer;
    import timer_pkg::*;

    localparam int TD    = 4;
    localparam int D1    = 3;
    localparam int D2    = 1;
    localparam int D3    = 0;
    localparam int D4    = 2;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [3:0]       sel = 4'b0000;
    logic             ld = 1'b0;
    logic [3:0]       T;
    logic             busy;
    logic [CNT_W-1:0] remaining;

    interval_timer #(
        .TICK_DIV (TD),
        .DUR1     (D1),
        .DUR2     (D2),
        .DUR3     (D3),
        .DUR4     (D4),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sel       (sel),
        .ld        (ld),
        .T         (T),
        .busy      (busy),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    // Edge counter; at a negedge, cyc equals the index of the last rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] t;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // Monitor: every nonzero T must match the next scoreboard entry in value and cycle.
    always @(negedge clk) begin
        if (cyc > 0 && T !== 4'b0000) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_T: got %b expected none (cycle %0d)", T, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("T_value", 32'(T), 32'(e.t));
                chk("T_cycle", cyc, e.at);
            end
        end
    end

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Issues a one-cycle command at a negedge; returns the edge k that samples it.
    task automatic issue(input logic [3:0] s, input logic l, output int k);
        sel = s;
        ld  = l;
        k   = cyc + 1;
        @(negedge clk);
        sel = SEL_NULL;
        ld  = 1'b0;
    endtask

    task automatic push(input logic [3:0] t, input int at);
        exp_t e;
        e.t  = t;
        e.at = at;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int k2;

        // 1. Reset overrides a load strobe.
        reset = 1'b0;
        ld    = 1'b1;
        sel   = SEL_T1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_T", 32'(T), 0);
            chk("reset_busy", 32'(busy), 0);
            chk("reset_rem", 32'(remaining), 0);
        end
        reset = 1'b1;
        ld    = 1'b0;
        sel   = SEL_NULL;
        @(negedge clk);
        chk("post_reset_busy", 32'(busy), 0);
        chk("post_reset_rem", 32'(remaining), 0);
        repeat (2) @(negedge clk);

        // 2. T1 full run.
        issue(SEL_T1, 1'b1, k);
        push(SEL_T1, k + D1 * TD);
        chk("t1_busy_start", 32'(busy), 1);
        chk("t1_rem_start", 32'(remaining), 3);
        wait_to(k + TD);
        chk("t1_rem_tick1", 32'(remaining), 2);
        wait_to(k + 2 * TD);
        chk("t1_rem_tick2", 32'(remaining), 1);
        chk("t1_busy_mid", 32'(busy), 1);
        wait_to(k + 3 * TD);
        chk("t1_busy_done", 32'(busy), 0);
        chk("t1_rem_done", 32'(remaining), 0);
        wait_to(k + 3 * TD + 3);
        chk("t1_busy_after", 32'(busy), 0);

        // 3. STOP without ld mid-count.
        issue(SEL_T1, 1'b1, k);
        wait_to(k + 5);
        issue(SEL_STOP, 1'b0, k2);
        chk("stop_busy", 32'(busy), 0);
        chk("stop_rem", 32'(remaining), 0);
        wait_to(k2 + 20);

        // 4. Restart T4 with T2 mid-count.
        issue(SEL_T4, 1'b1, k);
        wait_to(k + 4);
        issue(SEL_T2, 1'b1, k2);
        push(SEL_T2, k2 + D2 * TD);
        chk("restart_rem", 32'(remaining), 1);
        chk("restart_busy", 32'(busy), 1);
        wait_to(k + 20);

        // 5. Zero-length interval.
        issue(SEL_T3, 1'b1, k);
        push(SEL_T3, k + 1);
        wait_to(k + 6);
        chk("zero_busy_after", 32'(busy), 0);

        // 6a. STOP collides with the final tick of T1.
        issue(SEL_T1, 1'b1, k);
        wait_to(k + D1 * TD - 1);
        issue(SEL_STOP, 1'b0, k2);
        chk("collide_k", k2, k + D1 * TD);
        chk("collide_busy", 32'(busy), 0);
        chk("collide_rem", 32'(remaining), 0);
        wait_to(k2 + 20);

        // 6b. Non-one-hot select with ld is ignored while running.
        issue(SEL_T2, 1'b1, k);
        push(SEL_T2, k + D2 * TD);
        issue(4'b0011, 1'b1, k2);
        chk("bad_sel_busy", 32'(busy), 1);
        chk("bad_sel_rem", 32'(remaining), 1);
        wait_to(k + 10);

        // 6c. Ignored commands while idle.
        issue(4'b0011, 1'b1, k);
        chk("idle_bad_sel_busy", 32'(busy), 0);
        issue(SEL_T1, 1'b0, k);
        chk("no_ld_busy", 32'(busy), 0);
        chk("no_ld_rem", 32'(remaining), 0);
        wait_to(k + 20);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
